// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU among NREQ requesters; accept-to-response takes lat+1 cycles.
// Responses stall in RESP until rsp_ready, with no new grant meanwhile; ALU_SHARE_STATS_EN adds stat_ops/stat_wait counters.
module alu_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8,
    parameter int SRA_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_sel,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_sel,
    input  logic [31:0]          alu_out,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic                 busy
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [31:0]          stat_ops,
    output logic [31:0]          stat_wait
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, next_state;
    logic [IDW-1:0] last_grant, grant, cand, id;
    logic           found, accept, capture, div_zero;
    logic [31:0]    op_a, op_b, sel_a, sel_b;
    logic [3:0]     op_sel, sel_op, cnt;
    int             idx;

    function automatic logic [3:0] lat_of(input logic [3:0] s);
        case (s)
            4'b0010: lat_of = 4'(MUL_LAT);
            4'b0011: lat_of = 4'(DIV_LAT);
            4'b1111: lat_of = 4'(SRA_LAT);
            default: lat_of = 4'd1;
        endcase
    endfunction

    // Circular search starting just after the last winner, so it has lowest priority.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            cand = idx[IDW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
                sel_op = req_sel[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    next_state       = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_sel   = op_sel;
    assign div_zero  = (op_sel == 4'b0011) && (op_b == 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            id         <= '0;
            cnt        <= '0;
            last_grant <= IDW'(NREQ - 1);
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= sel_a;
                op_b       <= sel_b;
                op_sel     <= sel_op;
                id         <= grant;
                last_grant <= grant;
                cnt        <= lat_of(sel_op) - 4'd1;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_id    <= id;
                rsp_carry <= alu_carry;
                // A zero divisor yields an all-ones quotient regardless of what the ALU produced.
                if (div_zero) begin
                    rsp_data <= 32'hFFFF_FFFF;
                    rsp_zero <= 1'b0;
                    rsp_err  <= 1'b1;
                end else begin
                    rsp_data <= alu_out;
                    rsp_zero <= alu_zero;
                    rsp_err  <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_SHARE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_wait <= '0;
        end else begin
            if (rsp_valid && rsp_ready)
                stat_ops <= stat_ops + 32'd1;
            if ((|req_valid) && state != IDLE)
                stat_wait <= stat_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural stand-in for the shared ALU.
module tb_alu_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*4-1:0]    req_sel;
    logic [31:0]          alu_a, alu_b, alu_out;
    logic [3:0]           alu_sel;
    logic                 alu_carry, alu_zero;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_carry, rsp_zero, rsp_err, busy;

    int tests = 0;
    int fails = 0;
    int lat;
    int w;

    always #5 clk = ~clk;

    alu_share_ctrl #(
        .NREQ(NREQ), .IDW(IDW), .MUL_LAT(2), .DIV_LAT(8), .SRA_LAT(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .busy(busy)
    );

    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_sel)
            4'b0000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0010: alu_out = alu_a * alu_b;
            4'b0011: alu_out = (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
            4'b1000: alu_out = alu_a & alu_b;
            4'b1111: alu_out = $signed(alu_a) >>> alu_b[4:0];
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_sel[idx*4 +: 4] = sel;
    endtask

    // Single-requester op: checks same-cycle grant, then measures edges until rsp_valid.
    task automatic do_op(input int idx, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] b, output int cycles);
        set_req(idx, sel, a, b);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        #1;
        chk("grant", req_ready, 32'd1 << idx);
        step;
        req_valid = '0;
        cycles = 1;
        while (rsp_valid !== 1'b1 && cycles < 40) begin
            step;
            cycles++;
        end
        chk("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        step;
        step;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;

        // Basic add: 5+7
        do_op(0, 4'b0000, 32'd5, 32'd7, lat);
        chk("add_lat", lat, 2);
        chk("add_data", rsp_data, 12);
        chk("add_id", rsp_id, 0);
        chk("add_zero", rsp_zero, 0);
        chk("add_err", rsp_err, 0);
        step;
        chk("add_done_valid", rsp_valid, 0);
        chk("add_done_busy", busy, 0);

        // Round robin from fresh reset with all requesters held valid
        rst = 1'b1;
        step;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 4'b0000, 32'(16 * i + 1), 32'(i));
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            w = 0;
            while (req_ready == '0 && w < 10) begin
                step;
                w++;
            end
            chk("rr_grant", req_ready, 32'd1 << (n % 4));
            step;
            w = 0;
            while (rsp_valid !== 1'b1 && w < 10) begin
                step;
                w++;
            end
            chk("rr_id", rsp_id, n % 4);
            chk("rr_data", rsp_data, 17 * (n % 4) + 1);
            step;
        end

        // Divide 100/7 on requester 2, operands held through EXEC
        set_req(2, 4'b0011, 32'd100, 32'd7);
        req_valid = 4'b0100;
        #1;
        chk("div_grant", req_ready, 4'b0100);
        step;
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            chk("div_early_valid", rsp_valid, 0);
            chk("div_alu_a", alu_a, 100);
            chk("div_alu_b", alu_b, 7);
            step;
        end
        chk("div_valid", rsp_valid, 1);
        chk("div_data", rsp_data, 14);
        chk("div_id", rsp_id, 2);
        chk("div_err", rsp_err, 0);
        step;

        // Divide by zero, then AND to show the error flag clears
        do_op(1, 4'b0011, 32'd55, 32'd0, lat);
        chk("dz_lat", lat, 9);
        chk("dz_data", rsp_data, 32'hFFFF_FFFF);
        chk("dz_err", rsp_err, 1);
        chk("dz_zero", rsp_zero, 0);
        chk("dz_carry", rsp_carry, 0);
        chk("dz_id", rsp_id, 1);
        step;
        do_op(3, 4'b1000, 32'hF0, 32'h3C, lat);
        chk("and_lat", lat, 2);
        chk("and_data", rsp_data, 32'h30);
        chk("and_err", rsp_err, 0);
        chk("and_id", rsp_id, 3);
        step;

        // Response backpressure: 1+FFFFFFFF gives zero with carry
        rsp_ready = 1'b0;
        do_op(0, 4'b0000, 32'd1, 32'hFFFF_FFFF, lat);
        req_valid = 4'b1110;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 0);
            chk("stall_carry", rsp_carry, 1);
            chk("stall_zero", rsp_zero, 1);
            chk("stall_id", rsp_id, 0);
            chk("stall_req_ready", req_ready, 0);
            step;
        end
        rsp_ready = 1'b1;
        step;
        chk("stall_release_valid", rsp_valid, 0);
        chk("stall_release_busy", busy, 0);
        chk("stall_next_grant", req_ready, 4'b0010);
        req_valid = '0;

        // Reset in the middle of a multiply
        set_req(2, 4'b0010, 32'd6, 32'd7);
        req_valid = 4'b0100;
        #1;
        chk("mrst_grant", req_ready, 4'b0100);
        step;
        req_valid = '0;
        chk("mrst_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", rsp_valid, 0);
        chk("mrst_alu_a", alu_a, 0);
        chk("mrst_alu_b", alu_b, 0);
        chk("mrst_alu_sel", alu_sel, 0);
        chk("mrst_carry", rsp_carry, 0);
        chk("mrst_zero", rsp_zero, 0);
        chk("mrst_req_ready", req_ready, 0);
        step;
        step;
        chk("mrst_no_rsp", rsp_valid, 0);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mrst_first_grant", req_ready, 4'b0001);
        req_valid = '0;
        #1;

        // Multi-cycle latencies: multiply and arithmetic shift
        do_op(0, 4'b0010, 32'd6, 32'd7, lat);
        chk("mul_lat", lat, 3);
        chk("mul_data", rsp_data, 42);
        step;
        do_op(1, 4'b1111, 32'h8000_0000, 32'd4, lat);
        chk("sra_lat", lat, 3);
        chk("sra_data", rsp_data, 32'hF800_0000);
        step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
